// File: rtl/bram_be_requester_if.sv
// Request, response and RAM-port signal bundle for bram_be_requester.
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY
// are both high; VALID never waits on READY, and a held VALID keeps its
// payload stable until the transfer.
interface bram_be_requester_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_DATA;
  logic [BE_WIDTH-1:0]   REQ_BE;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_DATA;

  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_DI;
  logic [BE_WIDTH-1:0]   MEM_BE;
  logic                  MEM_WE;
  logic                  MEM_RE;
  logic [DATA_WIDTH-1:0] MEM_DO;

  logic                  BUSY;

  // The requester block itself.
  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, REQ_BE, RSP_READY, MEM_DO,
    output REQ_READY, RSP_VALID, RSP_DATA,
    output MEM_ADDR, MEM_DI, MEM_BE, MEM_WE, MEM_RE, BUSY
  );

  // The surrounding system: request source, response sink and the RAM.
  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, REQ_BE, RSP_READY, MEM_DO,
    input  REQ_READY, RSP_VALID, RSP_DATA,
    input  MEM_ADDR, MEM_DI, MEM_BE, MEM_WE, MEM_RE, BUSY
  );
endinterface

// File: rtl/bram_be_requester.sv
// Byte-enable RAM requester: forwards requests straight onto one RAM port,
// captures read data one cycle after the read and buffers it in a 3-entry
// response FIFO. Request acceptance is credit-based on registered state so a
// read is only issued when a FIFO slot is guaranteed for its data.
module bram_be_requester #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input logic                    CLK,
  input logic                    RST,
  bram_be_requester_if.slave     bus
);

  localparam int DEPTH = 3;

  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  in_flight;
  logic [1:0]            count;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            used;
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic [DATA_WIDTH-1:0] mem_di_w;
  logic [BE_WIDTH-1:0]   mem_be_w;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already spoken for: buffered words plus the read whose data is on
  // MEM_DO this cycle. Only registered state feeds REQ_READY.
  assign used          = {1'b0, count} + {2'b0, in_flight};
  assign bus.REQ_READY = !RST && (used < 3'(DEPTH));
  assign fire          = bus.REQ_VALID && bus.REQ_READY;

  // RAM port is a straight combinational pass-through of the request.
  assign mem_addr_w   = bus.REQ_ADDR;
  assign mem_di_w     = bus.REQ_DATA;
  assign mem_be_w     = bus.REQ_BE;
  assign bus.MEM_ADDR = mem_addr_w;
  assign bus.MEM_DI   = mem_di_w;
  assign bus.MEM_BE   = mem_be_w;
  assign bus.MEM_WE   = fire && bus.REQ_WE;
  assign bus.MEM_RE   = fire && !bus.REQ_WE;

  assign push          = in_flight;
  assign bus.RSP_VALID = !RST && (count != 2'd0);
  assign bus.RSP_DATA  = fifo_mem[rd_ptr];
  assign pop           = bus.RSP_VALID && bus.RSP_READY;
  assign bus.BUSY      = !RST && (in_flight || (count != 2'd0));

  // Track the single outstanding read; reset drops a read issued just before.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_flight <= 1'b0;
    end else begin
      in_flight <= fire && !bus.REQ_WE;
    end
  end

  // FIFO pointers and occupancy; push and pop together keep occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage captures RAM read data; contents survive reset untouched.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_mem[wr_ptr] <= bus.MEM_DO;
    end
  end

endmodule

// File: tb/tb_bram_be_requester.sv
// Bench for bram_be_requester: directed vector table, streaming and
// back-pressure sequences, then randomized traffic checked against a
// transaction-level model (outstanding-read queue plus shadow memory).
module tb_bram_be_requester;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_be_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  bram_be_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // RAM attached to the port: byte-enabled write, registered read data held
  logic [DW-1:0] ram [0:7] = '{default: '0};
  always @(posedge clk) begin
    if (bus.MEM_WE) begin
      for (int b = 0; b < BW; b++)
        if (bus.MEM_BE[b]) ram[bus.MEM_ADDR][8*b +: 8] <= bus.MEM_DI[8*b +: 8];
    end
    if (bus.MEM_RE) bus.MEM_DO <= ram[bus.MEM_ADDR];
  end

  // Scoreboard / reference model state
  logic [DW-1:0] exp_q[$];
  int            fire_cyc_q[$];
  logic [DW-1:0] shadow [0:7];
  int            cyc;
  int            checks;
  int            errors;

  // Values sampled in the last step
  logic          s_ready, s_rvalid, s_busy, s_fire;
  logic [DW-1:0] s_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Driver + model: apply one cycle of inputs, check outputs mid-cycle,
  // then advance the model across the clock edge.
  task automatic step(input logic r, input logic v, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic rr);
    logic e_ready, e_rvalid, e_busy, fire, pop;
    int   n_out;
    rst           = r;
    bus.REQ_VALID = v;
    bus.REQ_WE    = w;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = d;
    bus.REQ_BE    = be;
    bus.RSP_READY = rr;
    #3;
    // Reads issued in earlier cycles and not yet consumed hold a credit each;
    // a read's data is presentable two cycles after it was issued.
    n_out    = fire_cyc_q.size();
    e_ready  = !r && (n_out < 3);
    e_rvalid = !r && (n_out > 0) && (fire_cyc_q[0] <= cyc - 2);
    e_busy   = !r && (n_out > 0);
    fire     = v && e_ready;
    pop      = e_rvalid && rr;
    check("req_ready", bus.REQ_READY, e_ready);
    check("rsp_valid", bus.RSP_VALID, e_rvalid);
    check("busy", bus.BUSY, e_busy);
    check("mem_we", bus.MEM_WE, fire && w);
    check("mem_re", bus.MEM_RE, fire && !w);
    if (fire) begin
      check("mem_addr", bus.MEM_ADDR, a);
      if (w) begin
        check("mem_di", bus.MEM_DI, d);
        check("mem_be", bus.MEM_BE, be);
      end
    end
    if (e_rvalid) check("rsp_data", bus.RSP_DATA, exp_q[0]);
    s_ready  = bus.REQ_READY;
    s_rvalid = bus.RSP_VALID;
    s_busy   = bus.BUSY;
    s_rdata  = bus.RSP_DATA;
    s_fire   = v && bus.REQ_READY;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      fire_cyc_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(fire_cyc_q.pop_front());
      end
      if (fire && w) begin
        for (int b = 0; b < BW; b++)
          if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
      end
      if (fire && !w) begin
        exp_q.push_back(shadow[a]);
        fire_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic          rst;
    logic          vld;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          rrdy;
    logic          e_ready;
    logic          e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          e_busy;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic r, input logic v, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be, input logic rr,
                              input logic er, input logic ev,
                              input logic [DW-1:0] ed, input logic eb);
    vec_t t;
    t.rst = r; t.vld = v; t.we = w; t.addr = a; t.data = d; t.be = be; t.rrdy = rr;
    t.e_ready = er; t.e_rvalid = ev; t.e_rdata = ed; t.e_busy = eb;
    return t;
  endfunction

  initial begin
    int nrsp, nfire, rel_ready0, rel_ready1;
    checks = 0;
    errors = 0;
    cyc    = 0;
    bus.MEM_DO = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;

    //            rst vld we addr data     be     rrdy  rdy rv  rdata    busy
    tbl[0]  = mk(1, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    0, 0, 16'h0000, 0); // reset
    tbl[1]  = mk(1, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    0, 0, 16'h0000, 0);
    tbl[2]  = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0); // released
    tbl[3]  = mk(0, 1, 1, 3'd1, 16'h00A5, 2'b01, 1,    1, 0, 16'h0000, 0); // write A5
    tbl[4]  = mk(0, 1, 0, 3'd1, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0); // read 1
    tbl[5]  = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 1);
    tbl[6]  = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 1, 16'h00A5, 1); // t+2
    tbl[7]  = mk(0, 1, 1, 3'd2, 16'h0000, 2'b11, 1,    1, 0, 16'h0000, 0); // clear
    tbl[8]  = mk(0, 1, 1, 3'd2, 16'hBEEF, 2'b10, 1,    1, 0, 16'h0000, 0); // high byte
    tbl[9]  = mk(0, 1, 0, 3'd2, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0);
    tbl[10] = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 1);
    tbl[11] = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 1, 16'hBE00, 1);
    tbl[12] = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0);
    tbl[13] = mk(0, 1, 0, 3'd1, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0); // read, then
    tbl[14] = mk(1, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    0, 0, 16'h0000, 0); // reset hits
    tbl[15] = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0);
    tbl[16] = mk(0, 0, 0, 3'd0, 16'h0000, 2'b00, 1,    1, 0, 16'h0000, 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].rrdy);
      check("tbl_ready", s_ready, tbl[i].e_ready);
      check("tbl_rvalid", s_rvalid, tbl[i].e_rvalid);
      check("tbl_busy", s_busy, tbl[i].e_busy);
      if (tbl[i].e_rvalid) check("tbl_rdata", s_rdata, tbl[i].e_rdata);
    end

    // Fill every address with a distinct word so ordering is visible
    for (int i = 0; i < 8; i++)
      step(0, 1, 1, 3'(i), 16'(16'h1100 * (i + 1) + i), 2'b11, 1);
    step(0, 0, 0, 3'd0, 16'h0, 2'b00, 1);

    // Streaming reads 0..7 with the consumer always ready
    nrsp = 0;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        step(0, 1, 0, 3'(j), 16'h0, 2'b00, 1);
        check("stream_ready", s_ready, 1'b1);
      end else begin
        step(0, 0, 0, 3'd0, 16'h0, 2'b00, 1);
      end
      if (s_rvalid) begin
        check("stream_rsp_cycle", 32'(j), 32'(2 + nrsp));
        nrsp++;
      end
    end
    check("stream_rsp_count", 32'(nrsp), 32'd8);

    // Back-pressure: consumer stalled, reads offered continuously
    nfire = 0;
    for (int j = 0; j < 8; j++) begin
      step(0, 1, 0, 3'(j), 16'h0, 2'b00, 0);
      if (s_fire) nfire++;
    end
    check("bp_fires", 32'(nfire), 32'd3);
    check("bp_ready_low", s_ready, 1'b0);
    check("bp_rvalid_held", s_rvalid, 1'b1);
    nrsp = 0;
    rel_ready0 = 0;
    rel_ready1 = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 3'd0, 16'h0, 2'b00, 1);
      if (k == 0) rel_ready0 = int'(s_ready);
      if (k == 1) rel_ready1 = int'(s_ready);
      if (s_rvalid) nrsp++;
    end
    check("bp_ready_at_first_pop", 32'(rel_ready0), 32'd0);
    check("bp_ready_after_pop", 32'(rel_ready1), 32'd1);
    check("bp_rsp_count", 32'(nrsp), 32'd3);

    // Randomized traffic, occasional reset
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)),
           16'($urandom),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm idle
    for (int n = 0; n < 6; n++) step(0, 0, 0, 3'd0, 16'h0, 2'b00, 1);
    check("final_busy", s_busy, 1'b0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
